// File: rtl/addsub_seq.sv
// Multi-word add/subtract sequencer: streams a W-bit operand pair through one
// external DBW-bit addsub, LSW first, chaining carry/borrow between words.
module addsub_seq #(
  parameter int DBW = 8,
  parameter int NW  = 4,
  localparam int W  = DBW * NW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           op,
  input  logic           ci,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic           co,
  output logic           v,
  output logic           z,
  output logic           as_op,
  output logic           as_ci,
  output logic [DBW:0]   as_a,
  output logic [DBW:0]   as_b,
  input  logic [DBW-1:0] as_o,
  input  logic           as_co,
  input  logic           as_v
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           op_q, op_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   result_q, result_d;
  logic           co_q, co_d;
  logic           v_q, v_d;
  logic           z_q, z_d;

  logic [DBW-1:0] a_word;
  logic [DBW-1:0] b_word;
  logic           last_word;

  assign a_word    = a_q[idx_q*DBW +: DBW];
  assign b_word    = b_q[idx_q*DBW +: DBW];
  assign last_word = (idx_q == IW'(NW - 1));

  // The adder reports borrow as carry-out when subtracting, but expects
  // ci=1 to mean "no borrow", so the chained carry is inverted for subtract.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    co_d     = co_q;
    v_d      = v_q;
    z_d      = z_q;
    as_op    = 1'b0;
    as_ci    = 1'b0;
    as_a     = '0;
    as_b     = '0;

    case (state_q)
      ST_RUN: begin
        as_op   = op_q;
        as_ci   = carry_q;
        as_a    = {1'b0, a_word};
        as_b    = {1'b0, b_word};
        acc_d[idx_q*DBW +: DBW] = as_o;
        carry_d = op_q ? ~as_co : as_co;
        if (last_word) begin
          state_d  = ST_DONE;
          idx_d    = '0;
          result_d = acc_d;
          co_d     = as_co;
          v_d      = as_v;
          z_d      = (acc_d == '0);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, which allows back-to-back ops
        if (start) begin
          state_d = ST_RUN;
          op_d    = op;
          carry_d = ci;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      co_q     <= co_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign co     = co_q;
  assign v      = v_q;
  assign z      = z_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (DBW=8, NW=4) with a behavioural 8-bit addsub attached;
// expected results are queued at request time and checked on each done pulse.
module tb_addsub_seq;
  localparam int DBW = 8;
  localparam int NW  = 4;
  localparam int W   = DBW * NW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           op = 1'b0;
  logic           ci = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, co, v, z;
  logic [W-1:0]   result;
  logic           as_op, as_ci;
  logic [DBW:0]   as_a, as_b;
  logic [DBW-1:0] as_o;
  logic           as_co, as_v;
  logic [DBW:0]   adder_t;

  typedef struct {
    logic         op;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         v;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         v;
    logic         z;
    int           start_cyc;
    string        name;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];
  int   cyc = 0;
  int   n_applied = 0;
  int   n_miss = 0;

  addsub_seq #(.DBW(DBW), .NW(NW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .ci(ci),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .co(co), .v(v), .z(z), .as_op(as_op), .as_ci(as_ci),
    .as_a(as_a), .as_b(as_b), .as_o(as_o), .as_co(as_co), .as_v(as_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural addsub: carry-out on add, borrow-out on subtract, ci=1 means no borrow
  always_comb begin
    adder_t = '0;
    if (!as_op)
      adder_t = {1'b0, as_a[DBW-1:0]} + {1'b0, as_b[DBW-1:0]} + (DBW+1)'(as_ci);
    else
      adder_t = {1'b0, as_a[DBW-1:0]} - {1'b0, as_b[DBW-1:0]} - (DBW+1)'(!as_ci);
    as_o  = adder_t[DBW-1:0];
    as_co = adder_t[DBW];
    if (!as_op)
      as_v = (as_a[DBW-1] == as_b[DBW-1]) && (adder_t[DBW-1] != as_a[DBW-1]);
    else
      as_v = (as_a[DBW-1] != as_b[DBW-1]) && (adder_t[DBW-1] != as_a[DBW-1]);
  end

  function automatic exp_t model(input logic mop, input logic mci,
                                 input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input string name);
    exp_t e;
    logic [W:0] t;
    if (!mop) t = {1'b0, ma} + {1'b0, mb} + (W+1)'(mci);
    else      t = {1'b0, ma} - {1'b0, mb} - (W+1)'(!mci);
    e.res = t[W-1:0];
    e.co  = t[W];
    if (!mop) e.v = (ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]);
    else      e.v = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    e.z = (t[W-1:0] == '0);
    e.start_cyc = 0;
    e.name = name;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request as soon as the DUT is free; operands are scrambled
  // after acceptance to show the sequencer works from its latched copy.
  task automatic applyStimulus(input logic sop, input logic sci,
                               input logic [W-1:0] sa, input logic [W-1:0] sb,
                               input exp_t e);
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_applied++;
      n_miss++;
      $display("[TB] FAIL busy_timeout %s: busy still %b, expected 0", e.name, busy);
    end
    start = 1'b1;
    op = sop;
    ci = sci;
    a = sa;
    b = sb;
    e.start_cyc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom);
    ci = 1'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_applied++;
      n_miss++;
      $display("[TB] FAIL done_timeout: %0d results pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sbq.size() == 0) begin
        n_applied++;
        n_miss++;
        $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput({e.name, "_result"}, result, e.res);
        checkOutput({e.name, "_co"}, W'(co), W'(e.co));
        checkOutput({e.name, "_v"}, W'(v), W'(e.v));
        checkOutput({e.name, "_z"}, W'(z), W'(e.z));
        checkOutput({e.name, "_latency"}, W'(cyc - e.start_cyc), W'(NW + 1));
      end
    end
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h12345678, 32'h11111111, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", W'(busy), '0);
    checkOutput("rst_done", W'(done), '0);
    checkOutput("rst_result", result, '0);
    checkOutput("rst_co", W'(co), '0);
    checkOutput("rst_v", W'(v), '0);
    checkOutput("rst_z", W'(z), W'(1));
    checkOutput("rst_as_a", W'(as_a), '0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      exp_t e;
      e.res = vecs[i].res;
      e.co = vecs[i].co;
      e.v = vecs[i].v;
      e.z = vecs[i].z;
      e.start_cyc = 0;
      e.name = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].op, vecs[i].ci, vecs[i].a, vecs[i].b, e);
      checkOutput("run_busy", W'(busy), W'(1));
      checkOutput("run_as_a", W'(as_a), W'({1'b0, vecs[i].a[DBW-1:0]}));
      checkOutput("run_as_b", W'(as_b), W'({1'b0, vecs[i].b[DBW-1:0]}));
      checkOutput("run_as_op", W'(as_op), W'(vecs[i].op));
      if (i > 0) checkOutput("hold_result", result, vecs[i-1].res);
      drain();
      @(negedge clk);
      checkOutput("idle_as_a", W'(as_a), '0);
    end

    for (int i = 0; i < 12; i++) begin
      logic rop, rci;
      logic [W-1:0] ra, rb;
      rop = 1'($urandom);
      rci = 1'($urandom);
      ra = $urandom;
      rb = (i % 3 == 0) ? ra : W'($urandom);
      applyStimulus(rop, rci, ra, rb, model(rop, rci, ra, rb, $sformatf("rand%0d", i)));
      drain();
    end

    // Second start during RUN must be dropped; the scoreboard flags any extra done
    applyStimulus(1'b0, 1'b0, 32'h00000001, 32'h00000002,
                  model(1'b0, 1'b0, 32'h00000001, 32'h00000002, "ignored_start"));
    start = 1'b1;
    a = 32'hDEADBEEF;
    b = 32'h01010101;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Back-to-back: second request presented in the done cycle
    applyStimulus(1'b1, 1'b1, 32'h00001000, 32'h00000FFF,
                  model(1'b1, 1'b1, 32'h00001000, 32'h00000FFF, "b2b_first"));
    begin
      int k = 0;
      while (!done && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    applyStimulus(1'b0, 1'b1, 32'hAAAA5555, 32'h5555AAAA,
                  model(1'b0, 1'b1, 32'hAAAA5555, 32'h5555AAAA, "b2b_second"));
    checkOutput("b2b_busy", W'(busy), W'(1));
    drain();

    // Reset asserted during the second RUN word aborts the operation
    applyStimulus(1'b0, 1'b0, 32'h01020304, 32'h01010101,
                  model(1'b0, 1'b0, 32'h01020304, 32'h01010101, "aborted"));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sbq.delete();
    checkOutput("abort_busy", W'(busy), '0);
    checkOutput("abort_done", W'(done), '0);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_z", W'(z), W'(1));
    checkOutput("abort_as_a", W'(as_a), '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001,
                  model(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, "after_reset"));
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time %0t, expected finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
